// File: rtl/line_clear_ctrl_pkg.sv
// line_clear_ctrl_pkg: FSM state type and line-count to points mapping for line_clear_ctrl.
`include "header.v"
package line_clear_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, FLASH, COMMIT} state_t;
  function automatic logic [`SCORE_W-1:0] pts(input logic [4:0] n);
    return n >= 5'd4 ? `SCORE_W'(`SCORE_4)
         : n == 5'd3 ? `SCORE_W'(`SCORE_3)
         : n == 5'd2 ? `SCORE_W'(`SCORE_2)
         : n == 5'd1 ? `SCORE_W'(`SCORE_1)
         : '0;
  endfunction
endpackage

// File: rtl/header.v
// header: shared Tetris board geometry, row accessor and line-clear score constants.
`ifndef HEADER_V
`define HEADER_V
`define BOARD_W 10
`define BOARD_H 20
`define BOARD_SIZE (`BOARD_W * `BOARD_H)
`define GET_ROW_FILL(b, r) b[(r) * `BOARD_W +: `BOARD_W]
`define SCORE_1 40
`define SCORE_2 100
`define SCORE_3 300
`define SCORE_4 1200
`define SCORE_W 20
`endif

// File: rtl/line_clear_ctrl_clear.sv
// clear: combinational row compaction; full rows removed, survivors slide toward row 0, top filled with zeros.
`include "header.v"
module clear (
  input  logic [`BOARD_SIZE-1:0] board,
  output logic [`BOARD_SIZE-1:0] new_board,
  output logic [4:0]             num_to_clear
);
  int k;
  always_comb begin
    new_board = '0;
    k = 0;
    for (int r = 0; r < `BOARD_H; r++)
      if (!(&`GET_ROW_FILL(board, r))) begin
        new_board[k * `BOARD_W +: `BOARD_W] = `GET_ROW_FILL(board, r);
        k++;
      end
    num_to_clear = 5'(`BOARD_H - k);
  end
endmodule

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: post-lock line-clear sequencer with score/line statistics.
// Defining LINE_CLEAR_FLASH_EN adds a tick-timed flash phase before the board write-back.
`include "header.v"
module line_clear_ctrl
  import line_clear_ctrl_pkg::*;
#(
  parameter int FLASH_TICKS = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [`BOARD_SIZE-1:0] board_in,
  input  logic                   tick,
  input  logic                   clear_stats,
  output logic                   busy,
  output logic                   done,
  output logic                   board_we,
  output logic [`BOARD_SIZE-1:0] board_out,
  output logic [4:0]             lines_cleared,
  output logic [`BOARD_H-1:0]    flash_mask,
  output logic                   flash_on,
  output logic [`SCORE_W-1:0]    score,
  output logic [9:0]             total_lines
);
  state_t state, next;
  logic [`BOARD_SIZE-1:0] board_q, new_board;
  logic [4:0] num;
  logic flash_done;
  logic [`SCORE_W:0] score_sum;
  logic [10:0] lines_sum;

  clear u_clear (.board(board_q), .new_board(new_board), .num_to_clear(num));

`ifdef LINE_CLEAR_FLASH_EN
  localparam state_t AFTER_EVAL = FLASH;
  logic [`BOARD_H-1:0] full_mask;
  logic [3:0] tick_cnt;
  always_comb
    for (int r = 0; r < `BOARD_H; r++) full_mask[r] = &`GET_ROW_FILL(board_q, r);
  assign flash_done = tick && tick_cnt == 4'(FLASH_TICKS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tick_cnt <= '0;
      flash_mask <= '0;
      flash_on <= 1'b0;
    end else begin
      tick_cnt <= state == FLASH ? tick_cnt + 4'(tick) : '0;
      flash_mask <= next != FLASH ? '0 : state == EVAL ? full_mask : flash_mask;
      flash_on <= next == FLASH && (state == EVAL || (flash_on ^ tick));
    end
`else
  localparam state_t AFTER_EVAL = COMMIT;
  localparam int unused_flash_ticks = FLASH_TICKS;
  logic unused_tick;
  assign unused_tick = tick;
  assign flash_done = 1'b0;
  assign flash_mask = '0;
  assign flash_on = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;

  always_comb begin
    busy = state != IDLE;
    board_we = state == COMMIT;
    done = board_we || (state == EVAL && num == '0);
    next = state == IDLE  ? (start ? EVAL : IDLE)
         : state == EVAL  ? (num == '0 ? IDLE : AFTER_EVAL)
         : state == FLASH ? (flash_done ? COMMIT : FLASH)
         : IDLE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      board_q <= '0;
      board_out <= '0;
      lines_cleared <= '0;
    end else begin
      if (state == IDLE && start) board_q <= board_in;
      if (state == EVAL) begin
        board_out <= new_board;
        lines_cleared <= num;
      end
    end

  // one spare MSB on each sum flags overflow for saturation
  assign score_sum = {1'b0, score} + {1'b0, pts(lines_cleared)};
  assign lines_sum = {1'b0, total_lines} + 11'(lines_cleared);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      score <= '0;
      total_lines <= '0;
    end else if (clear_stats) begin
      score <= '0;
      total_lines <= '0;
    end else if (state == COMMIT) begin
      score <= score_sum[`SCORE_W] ? '1 : score_sum[`SCORE_W-1:0];
      total_lines <= lines_sum[10] ? '1 : lines_sum[9:0];
    end
endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: randomized scoreboard bench; reference model works on row lists and plain integer stats.
module tb_line_clear_ctrl;
  localparam int FT = 3;
  localparam int W = 10;
  localparam int H = 20;
`ifdef LINE_CLEAR_FLASH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk = 0, rst = 1, start = 0, tick = 0, clear_stats = 0;
  logic [W*H-1:0] board_in = '0;
  logic busy, done, board_we, flash_on;
  logic [W*H-1:0] board_out;
  logic [4:0] lines_cleared;
  logic [H-1:0] flash_mask;
  logic [19:0] score;
  logic [9:0] total_lines;

  typedef struct {
    bit we;
    logic [W*H-1:0] board;
    int lines;
    int score;
    int total;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t me, post;
  bit post_v = 0;
  int post_cyc, cyc = 0, n_chk = 0, n_pass = 0, m_score = 0, m_total = 0;

  line_clear_ctrl #(.FLASH_TICKS(FT)) dut (
    .clk(clk), .rst(rst), .start(start), .board_in(board_in), .tick(tick),
    .clear_stats(clear_stats), .busy(busy), .done(done), .board_we(board_we),
    .board_out(board_out), .lines_cleared(lines_cleared), .flash_mask(flash_mask),
    .flash_on(flash_on), .score(score), .total_lines(total_lines)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int pts_of(input int n);
    return n >= 4 ? 1200 : n == 3 ? 300 : n == 2 ? 100 : n == 1 ? 40 : 0;
  endfunction

  function automatic logic [W*H-1:0] mk(input logic [H-1:0] full);
    logic [W*H-1:0] b;
    for (int r = 0; r < H; r++) b[r*W +: W] = full[r] ? {W{1'b1}} : W'($urandom_range(0, 1022));
    return b;
  endfunction

  task automatic check_zero();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_board_we", board_we, 0);
    chk("rst_board_out", board_out, 0);
    chk("rst_lines_cleared", lines_cleared, 0);
    chk("rst_flash_mask", flash_mask, 0);
    chk("rst_flash_on", flash_on, 0);
    chk("rst_score", score, 0);
    chk("rst_total_lines", total_lines, 0);
  endtask

  task automatic do_op(input logic [H-1:0] full, input bit clr, input bit spur);
    logic [W*H-1:0] b;
    logic [W-1:0] keep[$];
    logic [H-1:0] fm;
    exp_t e;
    bit tq[$];
    bit in_fl;
    int t0, nt, tk, ph;
    b = mk(full);
    fm = '0;
    e.board = '0;
    for (int r = 0; r < H; r++) begin
      fm[r] = &b[r*W +: W];
      if (!fm[r]) keep.push_back(b[r*W +: W]);
    end
    foreach (keep[i]) e.board[i*W +: W] = keep[i];
    e.lines = H - keep.size();
    e.we = e.lines > 0;
    if (clr) begin
      m_score = 0;
      m_total = 0;
    end else if (e.we) begin
      m_score = m_score + pts_of(e.lines) > 20'hFFFFF ? 20'hFFFFF : m_score + pts_of(e.lines);
      m_total = m_total + e.lines > 1023 ? 1023 : m_total + e.lines;
    end
    e.score = m_score;
    e.total = m_total;
    @(posedge clk); #1;
    start = 1;
    board_in = b;
    t0 = cyc;
    nt = 0;
    e.done_cyc = t0 + (e.we ? 2 : 1);
    if (FL && e.we)
      for (int c = t0 + 1; nt < FT; c++) begin
        tk = $urandom_range(0, 1);
        tq.push_back(tk[0]);
        if (c >= t0 + 2 && tk == 1) nt++;
        e.done_cyc = c + 1;
      end
    sb.push_back(e);
    ph = 1;
    for (int cy = t0 + 1; cy <= e.done_cyc; cy++) begin
      @(posedge clk); #1;
      start = spur && cy == t0 + 1;
      board_in = mk(H'($urandom));
      tk = (cy - t0 - 1 < tq.size()) ? int'(tq[cy - t0 - 1]) : $urandom_range(0, 1);
      tick = tk[0];
      clear_stats = clr && cy == e.done_cyc;
      @(negedge clk);
      in_fl = FL && e.we && cy >= t0 + 2 && cy < e.done_cyc;
      chk("busy", busy, 1);
      chk("flash_mask", flash_mask, in_fl ? fm : '0);
      chk("flash_on", flash_on, in_fl ? ph[0] : 1'b0);
      if (cy >= t0 + 2 && tick) ph ^= 1;
    end
    @(posedge clk); #1;
    start = 0;
    tick = 0;
    clear_stats = 0;
  endtask

  always @(negedge clk) begin
    if (rst) post_v = 0;
    else begin
      if (post_v && cyc == post_cyc) begin
        chk("lines_cleared", lines_cleared, post.lines);
        chk("score", score, post.score);
        chk("total_lines", total_lines, post.total);
        chk("busy_after_done", busy, 0);
        post_v = 0;
      end
      if (done) begin
        chk("done_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          me = sb.pop_front();
          chk("done_cycle", cyc, me.done_cyc);
          chk("board_we", board_we, me.we);
          if (me.we) chk("board_out", board_out, me.board);
          post = me;
          post_v = 1;
          post_cyc = cyc + 1;
        end
      end else if (board_we) chk("we_implies_done", done, 1);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero();
    rst = 0;
    do_op(20'h00000, 0, 0);
    do_op(20'h00001, 0, 0);
    do_op(20'h00024, 0, 0);
    do_op(20'h0000F, 0, 0);
    do_op(20'h00001, 0, 1);
    do_op(20'h00003, 1, 0);
    do_op(20'h00000, 1, 1);
    repeat (40) do_op(H'($urandom & $urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    @(posedge clk); #1;
    start = 1;
    board_in = mk(20'h0000F);
    @(posedge clk); #1;
    start = 0;
`ifdef LINE_CLEAR_FLASH_EN
    @(posedge clk); #1;
    chk("pre_rst_flash_mask", flash_mask, 20'h0000F);
`endif
    rst = 1;
    #1;
    check_zero();
    m_score = 0;
    m_total = 0;
    @(posedge clk); #1;
    rst = 0;
    repeat (880) do_op(20'h0000F | H'($urandom & $urandom & $urandom), 0, $urandom_range(0, 1) == 1);
    repeat (2) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("score_saturated", score, 20'hFFFFF);
    chk("lines_saturated", total_lines, 10'd1023);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
